pattern_scan_ctrl: RTL

//  Sequencer and configuration front end for the serial pattern detectors.

---
 rtl/pattern_scan_if.sv | 31 +++
 rtl/pattern_scan_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pattern_scan_if.sv
// Bus-side bundle for pattern_scan_ctrl: word handshake, pattern configuration and match status.
// The bus-side word source uses master; the controller uses slave.
interface pattern_scan_if #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 8
);
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_ovl;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              hist_clr;
  logic              cnt_clr;
  logic              busy;
  logic              done;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_ovl, start, data_in, hist_clr, cnt_clr,
    input  busy, done, match_pulse, match_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_ovl, start, data_in, hist_clr, cnt_clr,
    output busy, done, match_pulse, match_count
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serialises a captured word MSB-first and matches the bit stream against a programmable
// 1..PAT_W bit pattern, counting matches with saturation.
module pattern_scan_ctrl #(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = 4,
  parameter int               LEN_W   = 3,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1011
) (
  input  logic          clk,
  input  logic          reset_n,
  pattern_scan_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [PAT_W-1:0]  hist_q,  hist_d;
  logic [LEN_W-1:0]  seen_q,  seen_d;
  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic              ovl_q,   ovl_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              shift_bit;
  logic [PAT_W-1:0]  hist_n;
  logic [LEN_W-1:0]  seen_n;
  logic [PAT_W-1:0]  len_mask;
  logic              hit;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    hist_d   = hist_q;
    seen_d   = seen_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    cnt_d    = cnt_q;
    hit      = 1'b0;
    len_mask = '0;

    shift_bit = word_q[idx_q];
    hist_n    = {hist_q[PAT_W-2:0], shift_bit};
    seen_n    = (seen_q == LEN_W'(PAT_W)) ? seen_q : seen_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end

    case (state_q)
      IDLE: begin
        // Config lands before the first shift, so a same-edge start uses the new pattern.
        if (bus.cfg_we) begin
          pat_d = bus.cfg_pattern;
          len_d = (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;
          ovl_d = bus.cfg_ovl;
        end
        if (bus.hist_clr) begin
          hist_d = '0;
          seen_d = '0;
        end
        if (bus.start) begin
          word_d  = bus.data_in;
          idx_d   = IDX_W'(DATA_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        hist_d = hist_n;
        seen_d = seen_n;
        hit    = (len_q != '0) && (seen_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
        if (hit && !ovl_q) seen_d = '0;
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    match_d = hit;
    if (bus.cnt_clr)                            cnt_d = '0;
    else if (hit && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      pat_q   <= RST_PAT;
      len_q   <= LEN_W'(PAT_W);
      ovl_q   <= 1'b1;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy        = (state_q == SHIFT);
  assign bus.done        = (state_q == DONE);
  assign bus.match_pulse = match_q;
  assign bus.match_count = cnt_q;

endmodule
